// File: rtl/pc_ctrl_pkg.sv
// Shared widths, FSM states and next-PC source codes for the PC sequencer.
package pc_ctrl_pkg;
   localparam int PC_W_DEF     = 8;
   localparam int RS_DEPTH_DEF = 4;

   typedef enum logic {
      ST_RUN,
      ST_HALTED
   } st_t;

   typedef enum logic [2:0] {
      SRC_HOLD,
      SRC_RET,
      SRC_TARGET,
      SRC_BRANCH,
      SRC_INC
   } src_t;
endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Control/PC bundle between the core's issue logic (master) and the sequencer (slave).
interface pc_seq_ctrl_if
   import pc_ctrl_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
);
   logic [PC_W-1:0] pc_cur;
   logic            stall;
   logic            halt;
   logic            resume;
   logic            branch_taken;
   logic [PC_W-1:0] branch_off;
   logic            jump;
   logic            call;
   logic            ret;
   logic [PC_W-1:0] target;
   logic [PC_W-1:0] pc_next;
   logic            halted;
   logic            rs_ovf;
   logic            rs_unf;

   modport master (
      output pc_cur, stall, halt, resume, branch_taken, branch_off,
             jump, call, ret, target,
      input  pc_next, halted, rs_ovf, rs_unf
   );

   modport slave (
      input  pc_cur, stall, halt, resume, branch_taken, branch_off,
             jump, call, ret, target,
      output pc_next, halted, rs_ovf, rs_unf
   );
endinterface

// File: rtl/pc_ret_stack.sv
// Circular return-address LIFO; a push while full overwrites the oldest entry.
module pc_ret_stack #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] top,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] ptr_reg;
   logic [AW:0]   count_reg;
   logic [AW-1:0] top_idx;

   // ptr_reg is the next free slot; when full it also points at the oldest entry.
   assign top_idx = ptr_reg - 1'b1;
   assign top     = mem[top_idx];
   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);

   always_ff @(posedge clk) begin
      if (push && !pop)
         mem[ptr_reg] <= din;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_reg   <= '0;
         count_reg <= '0;
      end else if (pop && !empty) begin
         ptr_reg   <= ptr_reg - 1'b1;
         count_reg <= count_reg - 1'b1;
      end else if (push) begin
         ptr_reg   <= ptr_reg + 1'b1;
         if (!full)
            count_reg <= count_reg + 1'b1;
      end
   end
endmodule

// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer with run/halt FSM; define PC_RET_STACK_EN to build
// the return-address stack for call/ret (otherwise call = jump, ret = increment).
module pc_seq_ctrl
   import pc_ctrl_pkg::*;
#(
   parameter int PC_W     = PC_W_DEF,
   parameter int RS_DEPTH = RS_DEPTH_DEF
) (
   input  logic         clk,
   input  logic         reset,
   pc_seq_ctrl_if.slave bus
);
   st_t             state_reg;
   st_t             state_next;
   src_t            src;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] rs_top;

   assign pc_inc = bus.pc_cur + 1'b1;

`ifdef PC_RET_STACK_EN
   logic rs_push;
   logic rs_pop;
   logic rs_full;
   logic rs_empty;
   logic rs_underflow;
   logic ovf_reg;
   logic unf_reg;

   pc_ret_stack #(
      .W     (PC_W),
      .DEPTH (RS_DEPTH)
   ) u_ret_stack (
      .clk   (clk),
      .reset (reset),
      .push  (rs_push),
      .pop   (rs_pop),
      .din   (pc_inc),
      .top   (rs_top),
      .full  (rs_full),
      .empty (rs_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_reg <= 1'b0;
         unf_reg <= 1'b0;
      end else begin
         if (rs_push && rs_full)
            ovf_reg <= 1'b1;
         if (rs_underflow)
            unf_reg <= 1'b1;
      end
   end

   assign bus.rs_ovf = ovf_reg;
   assign bus.rs_unf = unf_reg;
`else
   assign rs_top     = '0;
   assign bus.rs_ovf = 1'b0;
   assign bus.rs_unf = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_reg <= ST_RUN;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_RUN:    if (bus.halt)   state_next = ST_HALTED;
         ST_HALTED: if (bus.resume) state_next = ST_RUN;
         default:   state_next = ST_RUN;
      endcase
   end

   // Request priority: halt > stall > ret > call > jump > branch > increment.
   always_comb begin
      src = SRC_INC;
`ifdef PC_RET_STACK_EN
      rs_push      = 1'b0;
      rs_pop       = 1'b0;
      rs_underflow = 1'b0;
`endif
      if (state_reg == ST_HALTED || bus.halt || bus.stall) begin
         src = SRC_HOLD;
      end else if (bus.ret) begin
`ifdef PC_RET_STACK_EN
         if (rs_empty) begin
            rs_underflow = 1'b1;
         end else begin
            src    = SRC_RET;
            rs_pop = 1'b1;
         end
`endif
      end else if (bus.call) begin
         src = SRC_TARGET;
`ifdef PC_RET_STACK_EN
         rs_push = 1'b1;
`endif
      end else if (bus.jump) begin
         src = SRC_TARGET;
      end else if (bus.branch_taken) begin
         src = SRC_BRANCH;
      end
   end

   always_comb begin
      bus.pc_next = pc_inc;
      if (reset) begin
         bus.pc_next = '0;
      end else begin
         case (src)
            SRC_HOLD:   bus.pc_next = bus.pc_cur;
            SRC_RET:    bus.pc_next = rs_top;
            SRC_TARGET: bus.pc_next = bus.target;
            SRC_BRANCH: bus.pc_next = bus.pc_cur + bus.branch_off;
            default:    bus.pc_next = pc_inc;
         endcase
      end
   end

   assign bus.halted = (state_reg == ST_HALTED);
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl: vector table plus call/ret, halt and reset sequences.
module tb_pc_seq_ctrl;
   import pc_ctrl_pkg::*;

`ifdef PC_RET_STACK_EN
   localparam bit HAS_RS = 1'b1;
`else
   localparam bit HAS_RS = 1'b0;
`endif

   localparam logic [6:0] OP_BR = 7'h01;
   localparam logic [6:0] OP_JP = 7'h02;
   localparam logic [6:0] OP_CL = 7'h04;
   localparam logic [6:0] OP_RT = 7'h08;
   localparam logic [6:0] OP_ST = 7'h10;
   localparam logic [6:0] OP_HL = 7'h20;
   localparam logic [6:0] OP_RS = 7'h40;

   typedef struct {
      logic [7:0] pc;
      logic [6:0] ops;
      logic [7:0] off;
      logic [7:0] tgt;
      logic [7:0] exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       use_fb;
   logic [7:0] pc_drv;
   logic [7:0] pc_reg;
   int         n_vec = 0;
   int         n_err = 0;
   vec_t       tbl [10];

   pc_seq_ctrl_if bus ();

   pc_seq_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model of the plain PC register the sequencer feeds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pc_reg <= 8'h00;
      else       pc_reg <= bus.pc_next;
   end

   assign bus.pc_cur = use_fb ? pc_reg : pc_drv;

   function automatic vec_t mkv(input logic [7:0] pc, input logic [6:0] ops,
                                input logic [7:0] off, input logic [7:0] tgt,
                                input logic [7:0] exp);
      vec_t v;
      v.pc = pc; v.ops = ops; v.off = off; v.tgt = tgt; v.exp = exp;
      return v;
   endfunction

   task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      pc_drv           = v.pc;
      bus.branch_taken = v.ops[0];
      bus.jump         = v.ops[1];
      bus.call         = v.ops[2];
      bus.ret          = v.ops[3];
      bus.stall        = v.ops[4];
      bus.halt         = v.ops[5];
      bus.resume       = v.ops[6];
      bus.branch_off   = v.off;
      bus.target       = v.tgt;
   endtask

   // Called at posedge+1; checks pc_next before the next edge, returns at posedge+1.
   task automatic apply(input string nm, input vec_t v);
      drive(v);
      #2;
      chk8(nm, bus.pc_next, v.exp);
      $display("%s: pc_cur=0x%02h ops=0x%02h off=0x%02h tgt=0x%02h pc_next=0x%02h exp=0x%02h",
               nm, bus.pc_cur, v.ops, v.off, v.tgt, bus.pc_next, v.exp);
      @(posedge clk);
      #1;
      drive(mkv(v.pc, 7'h00, 8'h00, 8'h00, 8'h00));
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = mkv(8'h00, 7'h00,          8'h00, 8'h00, 8'h01);
      tbl[1] = mkv(8'hFF, 7'h00,          8'h00, 8'h00, 8'h00);
      tbl[2] = mkv(8'h10, OP_BR,          8'hF8, 8'h00, 8'h08);
      tbl[3] = mkv(8'h10, OP_BR | OP_JP,  8'hF8, 8'h40, 8'h40);
      tbl[4] = mkv(8'h02, OP_BR,          8'hFC, 8'h00, 8'hFE);
      tbl[5] = mkv(8'h7F, OP_BR,          8'h01, 8'h00, 8'h80);
      tbl[6] = mkv(8'h10, OP_ST | OP_JP,  8'h00, 8'h40, 8'h10);
      tbl[7] = mkv(8'h55, OP_JP,          8'h00, 8'hAA, 8'hAA);
      tbl[8] = mkv(8'hF0, OP_BR,          8'h20, 8'h00, 8'h10);
      tbl[9] = mkv(8'h33, OP_ST | OP_BR,  8'h04, 8'h00, 8'h33);

      reset  = 1'b1;
      use_fb = 1'b1;
      drive(mkv(8'h00, 7'h00, 8'h00, 8'h00, 8'h00));
      repeat (2) @(posedge clk);
      #1;
      chk8("rst_pc_next", bus.pc_next, 8'h00);
      chk8("rst_pc_cur", pc_reg, 8'h00);
      chk1("rst_halted", bus.halted, 1'b0);
      chk1("rst_ovf", bus.rs_ovf, 1'b0);
      chk1("rst_unf", bus.rs_unf, 1'b0);
      reset = 1'b0;

      // Free run with the PC register fed back.
      for (int i = 0; i < 5; i++) begin
         #1;
         chk8("run_pc_cur", pc_reg, 8'(i));
         chk8("run_pc_next", bus.pc_next, 8'(i + 1));
         $display("run: pc_cur=0x%02h pc_next=0x%02h", pc_reg, bus.pc_next);
         @(posedge clk);
         #1;
      end

      use_fb = 1'b0;
      for (int i = 0; i < 10; i++)
         apply("tbl", tbl[i]);

      // Single call then return.
      apply("call", mkv(8'h20, OP_CL, 8'h00, 8'h80, 8'h80));
      chk8("call_pc_reg", pc_reg, 8'h80);
      apply("ret", mkv(8'h85, OP_RT, 8'h00, 8'h00, HAS_RS ? 8'h21 : 8'h86));
      chk8("ret_pc_reg", pc_reg, HAS_RS ? 8'h21 : 8'h86);
      chk1("ret_unf", bus.rs_unf, 1'b0);

      // Five nested calls: the fifth overflows and discards return address 0x02.
      for (int k = 0; k < 5; k++) begin
         apply("ncall", mkv(8'(k + 1), OP_CL, 8'h00, 8'(8'hA0 + k), 8'(8'hA0 + k)));
         if (k == 3)
            chk1("ncall4_ovf", bus.rs_ovf, 1'b0);
      end
      chk1("ncall5_ovf", bus.rs_ovf, HAS_RS);
      for (int k = 0; k < 4; k++)
         apply("nret", mkv(8'hE0, OP_RT, 8'h00, 8'h00, HAS_RS ? 8'(6 - k) : 8'hE1));
      chk1("nret4_unf", bus.rs_unf, 1'b0);
      apply("nret5", mkv(8'hE0, OP_RT, 8'h00, 8'h00, 8'hE1));
      chk1("nret5_unf", bus.rs_unf, HAS_RS);

      // Halt at 0x30 with requests ignored, then resume.
      apply("jmp30", mkv(8'h00, OP_JP, 8'h00, 8'h30, 8'h30));
      use_fb = 1'b1;
      chk1("pre_halt", bus.halted, 1'b0);
      apply("halt", mkv(8'h00, OP_HL, 8'h00, 8'h00, 8'h30));
      chk1("halt_halted", bus.halted, 1'b1);
      for (int k = 0; k < 3; k++) begin
         apply("hreq", mkv(8'h00, OP_ST | OP_JP | OP_CL | OP_RT | OP_BR, 8'h05, 8'h99, 8'h30));
         chk1("hreq_halted", bus.halted, 1'b1);
         chk8("hreq_pc_reg", pc_reg, 8'h30);
      end
      apply("resume", mkv(8'h00, OP_RS | OP_JP, 8'h00, 8'h99, 8'h30));
      chk1("resume_halted", bus.halted, 1'b0);
      apply("post_resume", mkv(8'h00, 7'h00, 8'h00, 8'h00, 8'h31));
      chk8("post_resume_pc_reg", pc_reg, 8'h31);

      // Reset with two stacked return addresses.
      use_fb = 1'b0;
      apply("rcall1", mkv(8'h10, OP_CL, 8'h00, 8'h50, 8'h50));
      apply("rcall2", mkv(8'h11, OP_CL, 8'h00, 8'h60, 8'h60));
      drive(mkv(8'h61, OP_RT, 8'h00, 8'h00, 8'h00));
      reset = 1'b1;
      #1;
      chk8("mrst_pc_next", bus.pc_next, 8'h00);
      chk8("mrst_pc_reg", pc_reg, 8'h00);
      chk1("mrst_ovf", bus.rs_ovf, 1'b0);
      chk1("mrst_unf", bus.rs_unf, 1'b0);
      chk1("mrst_halted", bus.halted, 1'b0);
      @(posedge clk);
      #1;
      reset  = 1'b0;
      use_fb = 1'b1;
      apply("mrst_ret", mkv(8'h00, OP_RT, 8'h00, 8'h00, 8'h01));
      chk8("mrst_ret_pc_reg", pc_reg, 8'h01);
      chk1("mrst_ret_unf", bus.rs_unf, HAS_RS);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/pc_seq_ctrl.md
# pc_seq_ctrl

Next-PC sequencer for the 8-bit program counter register. Each cycle it selects the value loaded into the PC: increment, relative branch, absolute jump, subroutine call/return, stall or halt. It observes the current PC output and drives the PC input, so the PC register stays a plain loadable register. It holds a small return-address stack and a run/halt state machine.

## Interface
- PC_W, 8: PC width in bits
- RS_DEPTH, 4: return-stack depth (power of two, ≥2)

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high (same net as the PC register's reset)
- pc_cur  in  PC_W  current PC (PC register output)
- stall  in  1  hold PC this cycle
- halt  in  1  enter HALTED
- resume  in  1  leave HALTED
- branch_taken  in  1  take relative branch
- branch_off  in  PC_W  signed two's-complement offset
- jump  in  1  absolute jump
- call  in  1  push return address, jump
- ret  in  1  pop return address
- target  in  PC_W  absolute target for jump/call
- pc_next  out  PC_W  value for the PC register input
- halted  out  1  state is HALTED
- rs_ovf  out  1  sticky: call with stack full
- rs_unf  out  1  sticky: ret with stack empty

## Operation
- States: RUN, HALTED. Reset → RUN.
- RUN: pc_next is chosen by priority halt > stall > ret > call > jump > branch_taken > increment.
  - halt: pc_next = pc_cur; go to HALTED.
  - stall: pc_next = pc_cur; no stack change.
  - ret: pc_next = top of stack; pop.
  - call: push pc_cur+1, then pc_next = target.
  - jump: pc_next = target.
  - branch: pc_next = pc_cur + branch_off.
  - none of the above: pc_next = pc_cur + 1.
- HALTED: pc_next = pc_cur. All other requests are ignored. resume → RUN; the first RUN cycle takes the increment path.
- Arithmetic is mod 2^PC_W: 0xFF+1 = 0x00; branch offset is sign-extended, so 0x02 + 0xFC = 0xFE.
- Stack occupancy counts 0..RS_DEPTH.
  - call when full: the oldest entry is discarded, the new entry is pushed, the call is taken, and rs_ovf is set.
  - ret when empty: pc_next = pc_cur+1, no pop, and rs_unf is set.
- call and ret in the same cycle: ret wins and call is dropped.
- rs_ovf and rs_unf clear only on reset.

## Timing
- pc_next is combinational from pc_cur, the inputs and the registered state. The PC register loads it on the next clk edge, so a redirect is visible on pc_cur one cycle after the request.
- Stack push/pop, occupancy, state and flags update on posedge clk.
- Reset (asynchronous) values:
  - state RUN, occupancy 0, rs_ovf = 0, rs_unf = 0, halted = 0.
  - pc_next is driven to 0 while reset is high.
  - Reset mid-call or mid-halt discards all stack contents.
- halted rises the cycle after halt is sampled and falls the cycle after resume is sampled.

## Configuration
- PC_RET_STACK_EN defined:
  - return stack present, behaviour as above.
- PC_RET_STACK_EN undefined:
  - no stack storage.
  - call behaves as jump to target.
  - ret behaves as increment.
  - rs_ovf and rs_unf are tied to 0.

## Structure
- Package pc_ctrl_pkg holds:
  - PC_W default and RS_DEPTH default.
  - State enum (ST_RUN, ST_HALTED).
  - Next-PC source enum (SRC_HOLD, SRC_RET, SRC_TARGET, SRC_BRANCH, SRC_INC).
- Sub-module pc_ret_stack: circular LIFO with push/pop/full/empty and an overwrite-oldest-on-full rule. It is instantiated only under PC_RET_STACK_EN.

## Test plan
- Reset, then a free run with pc_cur fed back from the PC register → pc_next sequence 1,2,3…; 0xFF wraps to 0x00.
- At pc_cur=0x10:
  - branch_off=0xF8 → next pc_cur=0x08.
  - jump target=0x40 in the same cycle as the branch → next pc_cur=0x40 (jump wins).
- call target=0x80 at pc_cur=0x20, then ret at 0x85 → pc_cur goes 0x80 then 0x21; occupancy returns to 0.
- Five nested calls with RS_DEPTH=4 → rs_ovf=1; four rets return the latest four addresses; a fifth ret gives an increment and sets rs_unf=1.
- halt at pc_cur=0x30, then stall/jump for 3 cycles, then resume → pc_cur holds 0x30, then goes to 0x31; halted high for exactly the HALTED cycles.
- Reset asserted while the stack holds 2 entries → pc_cur=0; an immediate ret gives an increment and sets rs_unf.
